// File: rtl/chimera_clu_irq_collector.sv
// Cluster event collector: sticky pending bits, mask, claim and a level IRQ to the host.
// Define CHIMERA_CLU_IRQ_COUNT_EN to build the per-cluster saturating event counters.
module chimera_clu_irq_collector #(
  parameter int unsigned NumClusters = 5,
  parameter int unsigned CntWidth    = 8
) (
  input  logic                   soc_clk_i,
  input  logic                   rst_ni,
  input  logic [NumClusters-1:0] clu_evt_i,
  input  logic                   reg_req_valid_i,
  output logic                   reg_req_ready_o,
  input  logic [7:0]             reg_addr_i,
  input  logic                   reg_we_i,
  input  logic [31:0]            reg_wdata_i,
  output logic                   reg_rsp_valid_o,
  input  logic                   reg_rsp_ready_i,
  output logic [31:0]            reg_rdata_o,
  output logic                   reg_err_o,
  output logic                   irq_o
);

  typedef enum logic {Idle, Resp} state_e;

  state_e                 state_q;
  logic [NumClusters-1:0] pend_q, pend_d;
  logic [NumClusters-1:0] en_q, en_d;
  logic [NumClusters-1:0] clr, act;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   irq_q;
  logic                   acc, any;
  logic [4:0]             low;
  logic [5:0]             widx, cidx;
  logic                   sel_pend, sel_en, sel_stat;
  logic                   sel_clm, sel_cnt, sel_err;
  logic                   unused_bits;

  assign reg_req_ready_o = (state_q == Idle);
  assign reg_rsp_valid_o = (state_q == Resp);
  assign reg_rdata_o     = rdata_q;
  assign reg_err_o       = err_q;
  assign irq_o           = irq_q;

  assign acc  = reg_req_valid_i && reg_req_ready_o;
  assign widx = reg_addr_i[7:2];
  assign cidx = widx - 6'd4;
  assign act  = pend_q & en_q;
  assign any  = |act;

  assign sel_pend = (widx == 6'd0);
  assign sel_en   = (widx == 6'd1);
  assign sel_stat = (widx == 6'd2);
  assign sel_clm  = (widx == 6'd3);
  assign sel_cnt  = (widx >= 6'd4) &&
                    (widx < 6'(4 + NumClusters));
  assign sel_err  = !(sel_pend || sel_en || sel_stat ||
                      sel_clm || sel_cnt);

  assign unused_bits = ^{reg_addr_i[1:0],
                         reg_wdata_i[31:NumClusters]};

  always_comb begin
    low = '0;
    for (int i = NumClusters - 1; i >= 0; i--) begin
      if (act[i]) low = 5'(i);
    end
  end

`ifdef CHIMERA_CLU_IRQ_COUNT_EN
  logic [CntWidth-1:0]    cnt_q [NumClusters];
  logic [NumClusters-1:0] cnt_clr;
  logic [31:0]            cnt_rd;

  always_comb begin
    cnt_clr = '0;
    cnt_rd  = '0;
    for (int k = 0; k < NumClusters; k++) begin
      if (cidx == 6'(k)) begin
        cnt_rd     = 32'(cnt_q[k]);
        cnt_clr[k] = acc && sel_cnt && reg_we_i;
      end
    end
  end

  // An event in the clearing cycle still counts as one.
  always_ff @(posedge soc_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumClusters; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NumClusters; k++) begin
        if (clu_evt_i[k]) begin
          if (cnt_clr[k])
            cnt_q[k] <= CntWidth'(1);
          else if (cnt_q[k] != '1)
            cnt_q[k] <= cnt_q[k] + CntWidth'(1);
        end else if (cnt_clr[k]) begin
          cnt_q[k] <= '0;
        end
      end
    end
  end
`else
  logic [31:0] cnt_rd;
  assign cnt_rd = '0;
`endif

  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    clr     = '0;
    en_d    = en_q;
    if (acc) begin
      unique case (1'b1)
        sel_pend: begin
          if (reg_we_i) clr = reg_wdata_i[NumClusters-1:0];
          else rdata_d = 32'(pend_q);
        end
        sel_en: begin
          if (reg_we_i) en_d = reg_wdata_i[NumClusters-1:0];
          else rdata_d = 32'(en_q);
        end
        sel_stat: begin
          if (!reg_we_i) rdata_d = {any, 26'd0, low};
        end
        sel_clm: begin
          if (!reg_we_i) begin
            rdata_d = {any, 26'd0, low};
            for (int k = 0; k < NumClusters; k++) begin
              if (any && low == 5'(k)) clr[k] = 1'b1;
            end
          end
        end
        sel_cnt: begin
          if (!reg_we_i) rdata_d = cnt_rd;
        end
        sel_err: err_d = 1'b1;
      endcase
    end
  end

  // Set wins over a same-cycle W1C or claim.
  assign pend_d = (pend_q & ~clr) | clu_evt_i;

  always_ff @(posedge soc_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      pend_q  <= '0;
      en_q    <= '0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      en_q   <= en_d;
      irq_q  <= |(pend_d & en_d);
      unique case (state_q)
        Idle: begin
          if (acc) begin
            state_q <= Resp;
            rdata_q <= rdata_d;
            err_q   <= err_d;
          end
        end
        Resp: begin
          if (reg_rsp_ready_i) state_q <= Idle;
        end
        default: state_q <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_chimera_clu_irq_collector.sv
// Self-checking bench: directed table, corner sequences and random traffic
// against a cycle reference model of the register block.
module tb_chimera_clu_irq_collector;
  localparam int N    = 5;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  evt = '0;
  logic          valid = 1'b0;
  logic          ready;
  logic [7:0]    addr = '0;
  logic          we = 1'b0;
  logic [31:0]   wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rdata;
  logic          err;
  logic          irq;

  int checks = 0;
  int errors = 0;
  int rdelay = 0;
  bit run_chk = 1'b0;

  chimera_clu_irq_collector #(.NumClusters(N), .CntWidth(CW)) dut (
    .soc_clk_i(clk), .rst_ni(rst_n), .clu_evt_i(evt),
    .reg_req_valid_i(valid), .reg_req_ready_o(ready),
    .reg_addr_i(addr), .reg_we_i(we), .reg_wdata_i(wdata),
    .reg_rsp_valid_o(rsp_valid), .reg_rsp_ready_i(rsp_ready),
    .reg_rdata_o(rdata), .reg_err_o(err), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: registers kept as plain bit vectors and integers.
  logic [N-1:0] m_pend, m_en, m_clr, m_cclr;
  int           m_cnt [N];
  bit           m_resp, m_err, m_irq, m_acc;
  logic [31:0]  m_rd;
  int           m_wi;

  function automatic logic [31:0] m_status();
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_en[i]) return 32'h8000_0000 | i;
    return 32'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '0; m_en = '0; m_resp = 0;
      m_rd = '0; m_err = 0; m_irq = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      m_acc = valid && !m_resp;
      m_wi = int'(addr) / 4;
      m_clr = '0; m_cclr = '0;
      if (m_resp && rsp_ready) m_resp = 0;
      if (m_acc) begin
        m_rd = '0; m_err = 0;
        if (m_wi == 0) begin
          if (we) m_clr = wdata[N-1:0]; else m_rd = 32'(m_pend);
        end else if (m_wi == 1) begin
          if (!we) m_rd = 32'(m_en);
          else m_en = wdata[N-1:0];
        end else if (m_wi == 2 || m_wi == 3) begin
          if (!we) m_rd = m_status();
          if (!we && m_wi == 3 && m_rd[31]) m_clr[m_rd[4:0]] = 1'b1;
        end else if (m_wi >= 4 && m_wi < 4 + N) begin
`ifdef CHIMERA_CLU_IRQ_COUNT_EN
          if (we) m_cclr[m_wi-4] = 1'b1;
          else m_rd = m_cnt[m_wi-4];
`endif
        end else begin
          m_err = 1;
        end
        m_resp = 1;
      end
      m_pend = (m_pend & ~m_clr) | evt;
      for (int i = 0; i < N; i++) begin
        if (evt[i])
          m_cnt[i] = m_cclr[i] ? 1 : (m_cnt[i] < CMAX ? m_cnt[i] + 1 : CMAX);
        else if (m_cclr[i])
          m_cnt[i] = 0;
      end
      m_irq = |(m_pend & m_en);
    end
  end

  always @(negedge clk) begin
    if (rst_n && run_chk) begin
      chk("cyc_ready", 32'(ready), 32'(!m_resp));
      chk("cyc_rsp_valid", 32'(rsp_valid), 32'(m_resp));
      chk("cyc_irq", 32'(irq), 32'(m_irq));
      if (m_resp) begin
        chk("cyc_rdata", rdata, m_rd);
        chk("cyc_err", 32'(err), 32'(m_err));
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic xact(input logic [7:0] a, input logic w,
                      input logic [31:0] d, input logic [N-1:0] ev,
                      output logic [31:0] rd, output logic e);
    int n;
    valid = 1'b1; addr = a; we = w; wdata = d; evt = ev;
    n = 0;
    while (!ready && n < 20) begin cyc(); n++; end
    if (n == 20) chk("timeout_ready", 32'(ready), 32'd1);
    cyc();
    valid = 1'b0; evt = '0;
    n = 0;
    while (!rsp_valid && n < 20) begin cyc(); n++; end
    if (n == 20) chk("timeout_rsp", 32'(rsp_valid), 32'd1);
    rd = rdata; e = err;
    repeat (rdelay) cyc();
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic        w;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        tbl [15];
  logic [31:0] rd;
  logic        e;

  initial begin
    tbl[0]  = '{8'h00, 1'b0, 32'h0,        32'h0,  1'b0};
    tbl[1]  = '{8'h04, 1'b0, 32'h0,        32'h0,  1'b0};
    tbl[2]  = '{8'h08, 1'b0, 32'h0,        32'h0,  1'b0};
    tbl[3]  = '{8'h04, 1'b1, 32'hFFFFFFFF, 32'h0,  1'b0};
    tbl[4]  = '{8'h04, 1'b0, 32'h0,        32'h1F, 1'b0};
    tbl[5]  = '{8'h08, 1'b1, 32'h1234,     32'h0,  1'b0};
    tbl[6]  = '{8'h08, 1'b0, 32'h0,        32'h0,  1'b0};
    tbl[7]  = '{8'h0C, 1'b1, 32'hFF,       32'h0,  1'b0};
    tbl[8]  = '{8'h0C, 1'b0, 32'h0,        32'h0,  1'b0};
    tbl[9]  = '{8'h24, 1'b0, 32'h0,        32'h0,  1'b1};
    tbl[10] = '{8'h24, 1'b1, 32'h55,       32'h0,  1'b1};
    tbl[11] = '{8'hFC, 1'b0, 32'h0,        32'h0,  1'b1};
    tbl[12] = '{8'h11, 1'b0, 32'h0,        32'h0,  1'b0};
    tbl[13] = '{8'h04, 1'b1, 32'h0,        32'h0,  1'b0};
    tbl[14] = '{8'h07, 1'b0, 32'h0,        32'h0,  1'b0};

    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    run_chk = 1'b1;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);

    for (int i = 0; i < 15; i++) begin
      xact(tbl[i].a, tbl[i].w, tbl[i].d, '0, rd, e);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
    end

    // Masked event
    xact(8'h04, 1'b1, 32'h04, '0, rd, e);
    evt = 5'b00100; cyc(); evt = '0;
    chk("mask_irq", 32'(irq), 32'd1);
    xact(8'h08, 1'b0, 32'h0, '0, rd, e);
    chk("mask_status", rd, 32'h8000_0002);
    xact(8'h00, 1'b0, 32'h0, '0, rd, e);
    chk("mask_pending", rd, 32'h04);

    // Claim
    xact(8'h04, 1'b1, 32'h1F, '0, rd, e);
    xact(8'h00, 1'b1, 32'h1F, '0, rd, e);
    evt = 5'b00110; cyc(); evt = '0;
    xact(8'h0C, 1'b0, 32'h0, '0, rd, e);
    chk("claim1", rd, 32'h8000_0001);
    xact(8'h00, 1'b0, 32'h0, '0, rd, e);
    chk("claim_pend", rd, 32'h04);
    xact(8'h0C, 1'b0, 32'h0, '0, rd, e);
    chk("claim2", rd, 32'h8000_0002);
    chk("claim_irq_low", 32'(irq), 32'd0);

    // Collision: event wins over W1C
    evt = 5'b00001; cyc(); evt = '0;
    xact(8'h00, 1'b1, 32'h01, 5'b00001, rd, e);
    chk("coll_irq", 32'(irq), 32'd1);
    xact(8'h00, 1'b0, 32'h0, '0, rd, e);
    chk("coll_pend", rd, 32'h01);

    // Backpressure
    valid = 1'b1; addr = 8'h04; we = 1'b0;
    cyc(); valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rdata, 32'h1F);
      chk("bp_ready", 32'(ready), 32'd0);
      cyc();
    end
    rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;

    // Counters
    xact(8'h14, 1'b1, 32'h0, '0, rd, e);
    evt = 5'b00010;
    repeat (300) cyc();
    evt = '0;
    xact(8'h14, 1'b0, 32'h0, '0, rd, e);
`ifdef CHIMERA_CLU_IRQ_COUNT_EN
    chk("cnt_sat", rd, 32'd255);
    xact(8'h14, 1'b1, 32'h0, 5'b00010, rd, e);
    xact(8'h14, 1'b0, 32'h0, '0, rd, e);
    chk("cnt_clr_evt", rd, 32'd1);
`else
    chk("cnt_off_rdata", rd, 32'd0);
`endif
    chk("cnt_err", 32'(e), 32'd0);
    xact(8'h40, 1'b0, 32'h0, '0, rd, e);
    chk("unmapped_rdata", rd, 32'd0);
    chk("unmapped_err", 32'(e), 32'd1);

    // Reset during a pending response
    valid = 1'b1; addr = 8'h04; we = 1'b0;
    cyc(); valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_ready", 32'(ready), 32'd1);
    chk("rst_mid_irq", 32'(irq), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      logic [7:0] a;
      a = 8'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      rdelay = $urandom_range(0, 2);
      xact(a, 1'($urandom), $urandom, N'($urandom), rd, e);
      repeat ($urandom_range(0, 2)) begin
        evt = N'($urandom & $urandom);
        cyc();
      end
      evt = '0;
    end
    rdelay = 0;

    run_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
